// File: rtl/count_sequencer.sv
// Sequences a free-running up-counter through programmed passes.
// Supports pause/abort and emits per-pass tick and end-of-sequence done.
module count_sequencer #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_limit,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             pause,
  input  logic             abort,
  output logic [CNT_W-1:0] count,
  output logic [REP_W-1:0] rep_idx,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   count_q;
  logic [REP_W-1:0]   rep_q;
  logic [CNT_W-1:0]   limit_q;
  logic [REP_W-1:0]   reps_q;
  logic               tick_q;

  // Sequencer state and datapath; tick_q is a one-edge pulse set only on wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      rep_q   <= '0;
      limit_q <= '0;
      reps_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            limit_q <= cmd_limit;
            reps_q  <= cmd_reps;
            count_q <= '0;
            rep_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            count_q <= '0;
            rep_q   <= '0;
            state_q <= S_IDLE;
          end else if (pause) begin
            state_q <= S_HOLD;
          end else if (count_q == limit_q) begin
            count_q <= '0;
            tick_q  <= 1'b1;
            if (rep_q == reps_q) begin
              state_q <= S_DONE;
            end else begin
              rep_q <= rep_q + REP_W'(1);
            end
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (abort) begin
            count_q <= '0;
            rep_q   <= '0;
            state_q <= S_IDLE;
          end else if (!pause) begin
            state_q <= S_RUN;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Status flags decode directly from the registered state.
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN) || (state_q == S_HOLD);
  assign done      = (state_q == S_DONE);
  assign count     = count_q;
  assign rep_idx   = rep_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed self-checking bench for count_sequencer.
module tb_count_sequencer;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned REP_W = 4;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_limit;
  logic [REP_W-1:0] cmd_reps;
  logic             pause;
  logic             abort;
  logic [CNT_W-1:0] count;
  logic [REP_W-1:0] rep_idx;
  logic             busy;
  logic             tick;
  logic             done;

  int checks;
  int errors;

  count_sequencer #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_limit (cmd_limit),
    .cmd_reps  (cmd_reps),
    .pause     (pause),
    .abort     (abort),
    .count     (count),
    .rep_idx   (rep_idx),
    .busy      (busy),
    .tick      (tick),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a command for exactly one edge (E0) from IDLE.
  task automatic send_cmd(input logic [CNT_W-1:0] lim, input logic [REP_W-1:0] reps);
    cmd_valid = 1'b1;
    cmd_limit = lim;
    cmd_reps  = reps;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    logic [8:0] exp;
    rst = 1'b1;
    #3;
    got = {count, rep_idx, tick};
    exp = 9'b0;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_regs: got %b want %b", got, exp);
    end
    checks++;
    if ({cmd_ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: got %b want 100", {cmd_ready, busy, done});
    end
    #9 rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [CNT_W-1:0] ec;
    logic [REP_W-1:0] er;
    send_cmd(4'd3, 4'd1);
    checks++;
    if ({count, busy, cmd_ready} !== {4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL basic_accept: count=%0d busy=%b ready=%b want 0 1 0", count, busy, cmd_ready);
    end
    for (int i = 1; i <= 8; i++) begin
      step();
      ec = CNT_W'(i % 4);
      er = (i >= 4) ? REP_W'(1) : REP_W'(0);
      checks++;
      if ({count, rep_idx} !== {ec, er}) begin
        errors++;
        $display("FAIL basic_count E%0d: count=%0d rep=%0d want %0d %0d", i, count, rep_idx, ec, er);
      end
      checks++;
      if ({tick, done, busy} !== {(i == 4 || i == 8), (i == 8), (i < 8)}) begin
        errors++;
        $display("FAIL basic_flags E%0d: tick=%b done=%b busy=%b", i, tick, done, busy);
      end
    end
    step();
    checks++;
    if ({cmd_ready, tick, done} !== 3'b100) begin
      errors++;
      $display("FAIL basic_idle: got %b want 100", {cmd_ready, tick, done});
    end
  endtask

  task automatic test_limit_zero();
    send_cmd(4'd0, 4'd2);
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if ({count, rep_idx, tick} !== {4'd0, REP_W'(i < 3 ? i : 2), 1'b1}) begin
        errors++;
        $display("FAIL lim0 E%0d: count=%0d rep=%0d tick=%b", i, count, rep_idx, tick);
      end
      checks++;
      if ({done, busy} !== {(i == 3), (i < 3)}) begin
        errors++;
        $display("FAIL lim0_flags E%0d: done=%b busy=%b", i, done, busy);
      end
    end
    step();
    checks++;
    if ({tick, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL lim0_end: tick=%b ready=%b want 0 1", tick, cmd_ready);
    end
  endtask

  task automatic test_pause();
    logic [CNT_W-1:0] exp_cnt [1:9];
    exp_cnt = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
    send_cmd(4'd5, 4'd0);
    for (int i = 1; i <= 9; i++) begin
      pause = (i == 3 || i == 4);
      step();
      checks++;
      if (count !== exp_cnt[i]) begin
        errors++;
        $display("FAIL pause_count E%0d: got %0d want %0d", i, count, exp_cnt[i]);
      end
      checks++;
      if ({tick, done, busy} !== {(i == 9), (i == 9), (i < 9)}) begin
        errors++;
        $display("FAIL pause_flags E%0d: tick=%b done=%b busy=%b", i, tick, done, busy);
      end
    end
    pause = 1'b0;
    step();
  endtask

  task automatic test_abort();
    // Plain abort at count=4; a stray command offered mid-run must not latch.
    send_cmd(4'd7, 4'd2);
    for (int i = 1; i <= 4; i++) begin
      if (i == 2) begin
        cmd_valid = 1'b1;
        cmd_limit = 4'd1;
        cmd_reps  = 4'd0;
      end else begin
        cmd_valid = 1'b0;
      end
      step();
      checks++;
      if ({count, busy} !== {CNT_W'(i), 1'b1}) begin
        errors++;
        $display("FAIL abort_run E%0d: count=%0d busy=%b want %0d 1", i, count, busy, i);
      end
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({count, rep_idx, tick, done, busy, cmd_ready} !== {4'd0, 4'd0, 4'b0001}) begin
      errors++;
      $display("FAIL abort_plain: count=%0d rep=%0d t=%b d=%b b=%b r=%b",
               count, rep_idx, tick, done, busy, cmd_ready);
    end
    // Abort and pause together: abort wins.
    send_cmd(4'd7, 4'd0);
    step();
    step();
    abort = 1'b1;
    pause = 1'b1;
    step();
    abort = 1'b0;
    pause = 1'b0;
    checks++;
    if ({count, tick, done, cmd_ready} !== {4'd0, 3'b001}) begin
      errors++;
      $display("FAIL abort_pause: count=%0d t=%b d=%b r=%b", count, tick, done, cmd_ready);
    end
    // Abort while holding.
    send_cmd(4'd7, 4'd1);
    step();
    step();
    pause = 1'b1;
    step();
    step();
    checks++;
    if ({count, busy} !== {4'd2, 1'b1}) begin
      errors++;
      $display("FAIL hold_freeze: count=%0d busy=%b want 2 1", count, busy);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    pause = 1'b0;
    checks++;
    if ({count, rep_idx, tick, done, cmd_ready} !== {4'd0, 4'd0, 3'b001}) begin
      errors++;
      $display("FAIL abort_hold: count=%0d rep=%0d t=%b d=%b r=%b", count, rep_idx, tick, done, cmd_ready);
    end
    // Abort on the final wrap edge suppresses tick and done.
    send_cmd(4'd1, 4'd0);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({tick, done, cmd_ready, count} !== {3'b001, 4'd0}) begin
      errors++;
      $display("FAIL abort_wrap: t=%b d=%b r=%b count=%0d", tick, done, cmd_ready, count);
    end
  endtask

  task automatic test_max_limit();
    send_cmd(4'd15, 4'd0);
    for (int i = 1; i <= 15; i++) step();
    checks++;
    if ({count, tick} !== {4'd15, 1'b0}) begin
      errors++;
      $display("FAIL max_top: count=%0d tick=%b want 15 0", count, tick);
    end
    step();
    checks++;
    if ({count, tick, done} !== {4'd0, 2'b11}) begin
      errors++;
      $display("FAIL max_wrap: count=%0d tick=%b done=%b want 0 1 1", count, tick, done);
    end
    step();
    // Asynchronous reset mid-run at count=9.
    send_cmd(4'd15, 4'd0);
    for (int i = 1; i <= 9; i++) step();
    checks++;
    if (count !== 4'd9) begin
      errors++;
      $display("FAIL rst_pre: count=%0d want 9", count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({count, rep_idx, tick, cmd_ready, busy, done} !== {4'd0, 4'd0, 4'b0100}) begin
      errors++;
      $display("FAIL rst_async: count=%0d rep=%0d t=%b r=%b b=%b d=%b",
               count, rep_idx, tick, cmd_ready, busy, done);
    end
    #1 rst = 1'b0;
    step();
    step();
    checks++;
    if ({count, busy, cmd_ready} !== {4'd0, 2'b01}) begin
      errors++;
      $display("FAIL rst_no_resume: count=%0d busy=%b ready=%b", count, busy, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    send_cmd(4'd0, 4'd0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: busy=%b want 1", busy);
    end
    cmd_valid = 1'b1;
    cmd_limit = 4'd2;
    cmd_reps  = 4'd0;
    step();
    checks++;
    if ({done, cmd_ready} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_done: done=%b ready=%b want 1 0", done, cmd_ready);
    end
    step();
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_idle: ready=%b busy=%b want 1 0", cmd_ready, busy);
    end
    step();
    cmd_valid = 1'b0;
    checks++;
    if ({busy, count} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b count=%0d want 1 0", busy, count);
    end
    step();
    step();
    step();
    checks++;
    if ({tick, done, count} !== {2'b11, 4'd0}) begin
      errors++;
      $display("FAIL b2b_wrap: tick=%b done=%b count=%0d want 1 1 0", tick, done, count);
    end
    step();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_limit = '0;
    cmd_reps  = '0;
    pause     = 1'b0;
    abort     = 1'b0;
    test_reset();
    test_basic();
    test_limit_zero();
    test_pause();
    test_abort();
    test_max_limit();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
